// File: rtl/gray_sequencer.sv
// Gray-code phase sequencer: steps a 2^WIDTH-entry Gray sequence forward/reverse on a
// manual strobe or auto-step divider. Define GRAY_SEQ_STEPCNT_EN to add a 16-bit step counter.
module gray_sequencer #(
    parameter int WIDTH = 2,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             next,
    input  logic             dir,
    input  logic             auto_en,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] index,
    output logic             active,
`ifdef GRAY_SEQ_STEPCNT_EN
    output logic [15:0]      steps,
`endif
    output logic             wrap
);

    logic [DIV_W-1:0] count;
    logic             tick;
    logic             step;
    logic             at_edge;
    logic [WIDTH-1:0] next_index;

    always_comb begin
        // NOTE: compare against the live div; lowering div below count makes count
        // run on and wrap through 2^DIV_W rather than tick early.
        tick       = auto_en && (count == div);
        step       = next | tick;
        next_index = dir ? (index - 1'b1) : (index + 1'b1);
        at_edge    = dir ? (index == '0) : (index == '1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index  <= '0;
            gray   <= '0;
            count  <= '0;
            active <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            active <= 1'b1;
            if (clear) begin
                index <= '0;
                gray  <= '0;
                count <= '0;
                wrap  <= 1'b0;
            end else begin
                if (!auto_en || tick) begin
                    count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
                wrap <= step & at_edge;
                if (step) begin
                    index <= next_index;
                    gray  <= next_index ^ (next_index >> 1);
                end
            end
        end
    end

`ifdef GRAY_SEQ_STEPCNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            steps <= '0;
        end else if (clear) begin
            steps <= '0;
        end else if (step) begin
            steps <= steps + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gray_sequencer.sv
// Scoreboard bench for gray_sequencer: stimulus pushes model predictions, a monitor
// pops and compares one entry per clock. Honours GRAY_SEQ_STEPCNT_EN when defined.
module tb_gray_sequencer;

    localparam int WIDTH = 2;
    localparam int DIV_W = 8;
    localparam int N     = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             clear = 1'b0;
    logic             next = 1'b0;
    logic             dir = 1'b0;
    logic             auto_en = 1'b0;
    logic [DIV_W-1:0] div = '0;
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] index;
    logic             active;
    logic             wrap;
`ifdef GRAY_SEQ_STEPCNT_EN
    logic [15:0]      steps;
`endif

    gray_sequencer #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .next(next), .dir(dir),
        .auto_en(auto_en), .div(div), .gray(gray), .index(index), .active(active),
`ifdef GRAY_SEQ_STEPCNT_EN
        .steps(steps),
`endif
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int gry;
        int wrp;
        int act;
        int stp;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model state: position in the sequence and cycles into the auto period.
    int m_idx = 0;
    int m_cnt = 0;
    int m_act = 0;
    int m_stp = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_idx = 0; m_cnt = 0; m_act = 0; m_stp = 0;
    endtask

    task automatic model_edge(input bit c, input bit n, input bit d, input bit a,
                              input int dv, output exp_t e);
        int  new_idx;
        bit  tick;
        bit  wrp;
        wrp   = 1'b0;
        m_act = 1;
        if (c) begin
            m_idx = 0; m_cnt = 0; m_stp = 0;
        end else begin
            tick  = a && (m_cnt == dv);
            m_cnt = (a && !tick) ? (m_cnt + 1) % (1 << DIV_W) : 0;
            if (n || tick) begin
                new_idx = (m_idx + (d ? N - 1 : 1)) % N;
                // A wrap is any step that jumps against the direction of travel.
                wrp   = d ? (new_idx > m_idx) : (new_idx < m_idx);
                m_idx = new_idx;
                m_stp = (m_stp + 1) % 65536;
            end
        end
        e.idx = m_idx;
        e.gry = m_idx ^ (m_idx / 2);
        e.wrp = int'(wrp);
        e.act = m_act;
        e.stp = m_stp;
    endtask

    task automatic drive(input bit c, input bit n, input bit d, input bit a, input int dv);
        exp_t e;
        @(negedge clk);
        reset_n = 1'b1;
        clear   = c;
        next    = n;
        dir     = d;
        auto_en = a;
        div     = DIV_W'(dv);
        model_edge(c, n, d, a, dv, e);
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("index", int'(index), e.idx);
                check("gray", int'(gray), e.gry);
                check("wrap", int'(wrap), e.wrp);
                check("active", int'(active), e.act);
`ifdef GRAY_SEQ_STEPCNT_EN
                check("steps", int'(steps), e.stp);
`endif
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Reset held with a step request: nothing may move.
        next = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_index", int'(index), 0);
        check("rst_gray", int'(gray), 0);
        check("rst_active", int'(active), 0);
        check("rst_wrap", int'(wrap), 0);
        model_reset();

        // First edge after release both sets active and takes the pending step.
        drive(0, 1, 0, 0, 0);
        @(posedge clk);
        #2;
        check("first_edge_index", int'(index), 1);

        // Forward manual from 0: 01, 11, 10, 00 with wrap on the last.
        drive(1, 0, 0, 0, 0);
        repeat (4) drive(0, 1, 0, 0, 0);
        @(posedge clk);
        #2;
        check("fwd_wrap_gray", int'(gray), 0);
        check("fwd_wrap_pulse", int'(wrap), 1);

        // Reverse: 0 -> 3 (wrap), idle, 3 -> 2.
        drive(0, 1, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        @(posedge clk);
        #2;
        check("rev_gray", int'(gray), 2'b11);

        // Auto stepping at div=3, then div=0, then next coinciding with ticks.
        drive(1, 0, 0, 0, 0);
        repeat (12) drive(0, 0, 0, 1, 3);
        repeat (6)  drive(0, 0, 0, 1, 0);
        repeat (4)  drive(0, 1, 0, 1, 0);

        // Clear with a step pending at index 2; divider restarts.
        drive(1, 0, 0, 0, 0);
        repeat (2) drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 1, 3);
        repeat (9) drive(0, 0, 0, 1, 3);

        // Lowering div below the running count forces a long wrap-around.
        drive(1, 0, 0, 0, 0);
        repeat (5) drive(0, 0, 0, 1, 7);
        repeat (270) drive(0, 0, 0, 1, 2);

        // Async reset between edges while auto stepping at index 3.
        drive(1, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 1, 0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_index", int'(index), 0);
        check("async_gray", int'(gray), 0);
        check("async_active", int'(active), 0);
        check("async_wrap", int'(wrap), 0);
        model_reset();
        auto_en = 1'b0;
        repeat (2) @(posedge clk);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 3, 1'($urandom),
                  $urandom_range(0, 9) < 7, ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255)
                                                                       : $urandom_range(0, 5));
        end

        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
